qdec_step_gen: RTL

- Quadrature-encoder front end that sits directly upstream of the 8-bit up/down counter (TOP).
- Synchronises and glitch-filters raw A/B/Z encoder pins, then decodes direction.
- Drives the counter's UP, DN, LOAD and DIN inputs with single-cycle pulses.
- Flags illegal quadrature transitions for software.

---
 rtl/qdec_step_gen.sv | 130 +++++++++++++
 1 files changed

// File: rtl/qdec_step_gen.sv
// qdec_step_gen: quadrature encoder front end for an 8-bit up/down counter.
// Synchronises and glitch-filters the A/B/Z pins, decodes direction into single-cycle UP/DN pulses,
// issues a LOAD of HOME_VAL on an index rising edge and flags illegal A/B transitions.
// Optional macro QDEC_X4_EN: x4 decoding (a pulse on every legal step). Undefined: x1 decoding.
module qdec_step_gen #(
  parameter int unsigned FILT_LEN = 4,      // 1..15 cycles of disagreement before f follows s
  parameter logic [7:0]  HOME_VAL = 8'h00
) (
  input  logic       i_clk,
  input  logic       i_res,
  input  logic       i_enc_a,
  input  logic       i_enc_b,
  input  logic       i_enc_z,
  input  logic       i_err_clr,
  output logic       o_up,
  output logic       o_dn,
  output logic       o_load,
  output logic [7:0] o_din,
  output logic       o_err,
  output logic       o_err_flag
);

  typedef enum logic {StInit, StRun} state_e;

  // INIT lasts FILT_LEN+2 cycles: counter runs 0..FILT_LEN+1
  localparam logic [4:0] InitLast = 5'(FILT_LEN + 1);
  localparam logic [3:0] FiltLast = 4'(FILT_LEN - 1);

  // Channel bit order in the vectors below: [2]=A, [1]=B, [0]=Z
  logic [2:0] r_sync1;
  logic [2:0] r_sync2;
  logic [2:0] r_filt;
  logic [3:0] r_fcnt [3];
  logic [1:0] r_prev;
  logic       r_prevz;
  logic [4:0] r_init_cnt;
  state_e     r_state;

  logic [1:0] w_cur;
  logic       w_fwd;
  logic       w_rev;
  logic       w_ill;
  logic       w_up;
  logic       w_dn;

  assign w_cur = r_filt[2:1];

  // Classify the filtered {A,B} transition relative to the previous cycle
  always_comb begin
    w_fwd = 1'b0;
    w_rev = 1'b0;
    w_ill = 1'b0;
    case ({r_prev, w_cur})
      4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: w_fwd = 1'b1;
      4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: w_rev = 1'b1;
      4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: w_ill = 1'b1;
      default: ;
    endcase
`ifdef QDEC_X4_EN
    w_up = w_fwd;
    w_dn = w_rev;
`else
    // x1: only the step across the 00 detent produces a pulse
    w_up = w_fwd && (r_prev == 2'b10);
    w_dn = w_rev && (r_prev == 2'b00);
`endif
  end

  // Sync chain, filters, INIT/RUN state machine and registered outputs
  always_ff @(posedge i_clk) begin
    if (i_res) begin
      r_sync1    <= 3'b000;
      r_sync2    <= 3'b000;
      r_filt     <= 3'b000;
      for (int c = 0; c < 3; c++) r_fcnt[c] <= 4'd0;
      r_prev     <= 2'b00;
      r_prevz    <= 1'b0;
      r_init_cnt <= 5'd0;
      r_state    <= StInit;
      o_up       <= 1'b0;
      o_dn       <= 1'b0;
      o_load     <= 1'b0;
      o_din      <= 8'h00;
      o_err      <= 1'b0;
      o_err_flag <= 1'b0;
    end else begin
      r_sync1 <= {i_enc_a, i_enc_b, i_enc_z};
      r_sync2 <= r_sync1;
      r_prev  <= w_cur;
      r_prevz <= r_filt[0];

      case (r_state)
        StInit: begin
          // Filter bypassed so f/prev track the pins without producing steps
          r_filt <= r_sync2;
          for (int c = 0; c < 3; c++) r_fcnt[c] <= 4'd0;
          o_up   <= 1'b0;
          o_dn   <= 1'b0;
          o_load <= 1'b0;
          o_din  <= 8'h00;
          o_err  <= 1'b0;
          if (r_init_cnt == InitLast) r_state <= StRun;
          else r_init_cnt <= r_init_cnt + 5'd1;
        end
        default: begin
          for (int c = 0; c < 3; c++) begin
            if (r_sync2[c] == r_filt[c]) begin
              r_fcnt[c] <= 4'd0;
            end else if (r_fcnt[c] == FiltLast) begin
              r_filt[c] <= r_sync2[c];
              r_fcnt[c] <= 4'd0;
            end else begin
              r_fcnt[c] <= r_fcnt[c] + 4'd1;
            end
          end
          o_up   <= w_up;
          o_dn   <= w_dn;
          o_err  <= w_ill;
          o_load <= r_filt[0] & ~r_prevz;
          o_din  <= (r_filt[0] & ~r_prevz) ? HOME_VAL : 8'h00;
        end
      endcase

      // A new error beats a simultaneous clear
      if ((r_state == StRun) && w_ill) o_err_flag <= 1'b1;
      else if (i_err_clr)              o_err_flag <= 1'b0;
    end
  end

endmodule
